// File: rtl/sp_ram_bus_if.sv
// picorv32-native memory bus between a CPU-side master and a decoded slave.
interface sp_ram_bus_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    mem_valid;
    logic [31:0]             mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    mem_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/sp_ram_bus.sv
// Single-port RAM behind a picorv32 memory-bus slave: window decode, byte strobes,
// registered ready pulse and an optional read-data pipeline stage.
module sp_ram_bus #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic            clk,
    input  logic            reset,
    sp_ram_bus_if.slave     bus,
    output logic            hit,
    output logic            busy
);
    localparam int unsigned NB      = DATA_WIDTH / 8;
    localparam int unsigned OFS     = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned TAG_LSB = ADDR_WIDTH + OFS;
    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam bit          PIPE    = (OUT_REG != 0);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ACK  = 3'd1;
    localparam logic [2:0] RD      = 3'd2;
    localparam logic [2:0] RD_PIPE = 3'd3;
    localparam logic [2:0] RD_ACK  = 3'd4;

    logic [2:0]            state_q;
    logic [2:0]            state_d;
    logic                  ready_q;
    logic                  ready_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  busy_q;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] pipe_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Tag compare: everything above the window size must match the base.
    assign hit = bus.mem_valid && (bus.mem_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign idx = bus.mem_addr[TAG_LSB-1:OFS];

    generate
        if (OFS > 0) begin : g_lane_bits
            logic unused_lane_bits;
            assign unused_lane_bits = ^bus.mem_addr[OFS-1:0];
        end
    endgenerate

    // RAM array: per-lane writes, synchronous read; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.mem_wstrb[i]) begin
                    mem[idx][i*8 +: 8] <= bus.mem_wdata[i*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            ram_q <= mem[idx];
        end
    end

    generate
        if (PIPE) begin : g_pipe
            always_ff @(posedge clk) begin
                if (state_q == RD) begin
                    pipe_q <= ram_q;
                end
            end
        end else begin : g_no_pipe
            assign pipe_q = ram_q;
        end
    endgenerate

    // Next-state and registered-output decode; ACK states never look at the bus.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (|bus.mem_wstrb) begin
                        wr_en   = 1'b1;
                        state_d = WR_ACK;
                    end else begin
                        rd_en   = 1'b1;
                        state_d = RD;
                    end
                end
            end
            WR_ACK:  state_d = IDLE;
            RD:      state_d = PIPE ? RD_PIPE : RD_ACK;
            RD_PIPE: state_d = PIPE ? RD_ACK : IDLE;
            RD_ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == WR_ACK) || (state_d == RD_ACK);
        if (state_d == RD_ACK) begin
            rdata_d = pipe_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign busy          = busy_q;
endmodule
